// File: rtl/gol_scanout_if.sv
// Row-stream bus between the Game of Life scanout engine and its sink.
// Handshake: a beat transfers on a rising clk edge when row_valid and
// row_ready are both 1; row_valid, once high, stays high with row_data,
// row_idx, sof and eof held stable until that transfer happens, and
// row_ready is don't-care while row_valid is 0.
interface gol_scanout_if #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [WIDTH*HEIGHT-1:0] cells;
  logic                    snap_req;
  logic                    row_ready;
  logic                    row_valid;
  logic [WIDTH-1:0]        row_data;
  logic [RW-1:0]           row_idx;
  logic                    sof;
  logic                    eof;
  logic                    busy;
  logic [15:0]             frame_count;
  logic [7:0]              drop_count;

  // Scanout engine side: sources the row stream.
  modport master (
    input  cells, snap_req, row_ready,
    output row_valid, row_data, row_idx, sof, eof, busy,
           frame_count, drop_count
  );

  // Sink / controller side.
  modport slave (
    output cells, snap_req, row_ready,
    input  row_valid, row_data, row_idx, sof, eof, busy,
           frame_count, drop_count
  );
endinterface

// File: rtl/gol_scanout.sv
// Game of Life readout engine: snapshots the whole cell array in one cycle
// on snap_req, then streams it one row per beat with sof/eof flags.
// Requests arriving mid-frame are dropped and counted; a request on the
// final accepted beat starts the next frame with no idle cycle.
module gol_scanout #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
) (
  input  logic              clk,
  input  logic              rst,
  gol_scanout_if.master     bus,
  output logic              state_dbg_o
);
  localparam int            RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [RW-1:0] LAST = RW'(HEIGHT - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH*HEIGHT-1:0] snap_q, snap_d;
  logic [RW-1:0]           cnt_q, cnt_d;
  logic [15:0]             frame_q, frame_d;
  logic [7:0]              drop_q, drop_d;
  logic                    row_valid_q, row_valid_d;
  logic [WIDTH-1:0]        row_data_q, row_data_d;
  logic [RW-1:0]           row_idx_q, row_idx_d;
  logic                    sof_q, sof_d;
  logic                    eof_q, eof_d;

  // Next-state logic; outputs are derived from the next state so that
  // every output leaves a flop.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (bus.snap_req) begin
          snap_d  = bus.cells;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.row_ready && (cnt_q == LAST)) begin
          frame_d = frame_q + 16'd1;
          cnt_d   = '0;
          if (bus.snap_req) begin
            snap_d = bus.cells;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (bus.row_ready) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (bus.snap_req && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    row_valid_d = (state_d == SEND);
    row_data_d  = row_valid_d ? snap_d[int'(cnt_d)*WIDTH +: WIDTH] : '0;
    row_idx_d   = row_valid_d ? cnt_d : '0;
    sof_d       = row_valid_d && (cnt_d == '0);
    eof_d       = row_valid_d && (cnt_d == LAST);
  end

  // State, snapshot, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      cnt_q       <= '0;
      frame_q     <= '0;
      drop_q      <= '0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_idx_q   <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      drop_q      <= drop_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      row_idx_q   <= row_idx_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
    end
  end

  assign bus.row_valid   = row_valid_q;
  assign bus.row_data    = row_data_q;
  assign bus.row_idx     = row_idx_q;
  assign bus.sof         = sof_q;
  assign bus.eof         = eof_q;
  assign bus.busy        = (state_q == SEND);
  assign bus.frame_count = frame_q;
  assign bus.drop_count  = drop_q;
  assign state_dbg_o     = (state_q == SEND);
endmodule

// File: tb/tb_gol_scanout.sv
// Bench for gol_scanout: a 10x10 instance driven through the full test
// sequence with a beat scoreboard, plus a 4x1 instance for the one-row case.
module tb_gol_scanout;
  logic clk = 1'b0;
  logic rst;
  logic dbg0, dbg1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  // Expected beats: {row_idx[3:0], sof, eof, row_data[9:0]}
  logic [15:0] exp_q[$];

  gol_scanout_if #(.WIDTH(10), .HEIGHT(10)) bus0 ();
  gol_scanout_if #(.WIDTH(4),  .HEIGHT(1))  bus1 ();

  gol_scanout #(.WIDTH(10), .HEIGHT(10)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.master), .state_dbg_o(dbg0)
  );
  gol_scanout #(.WIDTH(4), .HEIGHT(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.master), .state_dbg_o(dbg1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        stall_prev = 1'b0;
  logic [16:0] stall_val;

  always @(negedge clk) begin
    logic [15:0] obs;
    obs = {bus0.row_idx, bus0.sof, bus0.eof, bus0.row_data};
    if (!mon_en) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", {15'd0, bus0.row_valid, obs},
                            {15'd0, stall_val});
      if (bus0.row_valid && bus0.row_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
        else check("beat", {16'd0, obs}, {16'd0, exp_q.pop_front()});
      end
      stall_prev = bus0.row_valid && !bus0.row_ready;
      stall_val  = {bus0.row_valid, obs};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [99:0] c);
    for (int r = 0; r < 10; r++)
      exp_q.push_back({4'(r), (r == 0), (r == 9), c[r*10 +: 10]});
  endtask

  function automatic logic [99:0] rand_cells();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[99:0];
  endfunction

  // Capture c on the next edge (DUT must be idle), expect its 10 rows.
  task automatic start_frame(input logic [99:0] c);
    bus0.cells    = c;
    bus0.snap_req = 1'b1;
    push_frame(c);
    tick();
    bus0.snap_req = 1'b0;
  endtask

  // Apply a repeating 4-cycle row_ready pattern until the queue drains.
  task automatic drain(input logic [3:0] pat, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 300) begin
      bus0.row_ready = pat[cycles % 4];
      tick();
      cycles++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [99:0] c, b;
    int          cyc;

    rst = 1'b0;
    bus0.cells = '0; bus0.snap_req = 1'b0; bus0.row_ready = 1'b0;
    bus1.cells = '0; bus1.snap_req = 1'b0; bus1.row_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", bus0.row_valid, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_dbg_state", dbg0, 0);
    check("rst_frames", bus0.frame_count, 0);
    check("rst_drops", bus0.drop_count, 0);
    rst = 1'b1;
    repeat (2) tick();
    mon_en = 1'b1;

    // Basic 10x10 frame with a fixed pattern and row_ready held high.
    c = '0;
    c[9:0]   = 10'h3FF;
    c[99:90] = 10'h201;
    bus0.row_ready = 1'b1;
    start_frame(c);
    check("latency_valid", bus0.row_valid, 1);
    check("latency_sof", bus0.sof, 1);
    check("busy_in_frame", bus0.busy, 1);
    drain(4'hF, cyc);
    check("frame_cycles", cyc, 10);
    check("basic_busy_after", bus0.busy, 0);
    check("basic_valid_after", bus0.row_valid, 0);
    check("basic_frames", bus0.frame_count, 1);

    // Asynchronous reset while row 4 is on the bus.
    start_frame(rand_cells());
    repeat (4) tick();
    check("pre_reset_idx", bus0.row_idx, 4);
    mon_en = 1'b0;
    exp_q.delete();
    #2 rst = 1'b0;
    #1;
    check("arst_valid", bus0.row_valid, 0);
    check("arst_data", bus0.row_data, 0);
    check("arst_idx", bus0.row_idx, 0);
    check("arst_sof_eof", {bus0.sof, bus0.eof}, 0);
    check("arst_busy", bus0.busy, 0);
    check("arst_frames", bus0.frame_count, 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("post_reset_valid", bus0.row_valid, 0);
    check("post_reset_frames", bus0.frame_count, 0);
    mon_en = 1'b1;

    // Backpressure: row_ready pattern 1,0,0,1,...
    start_frame(rand_cells());
    drain(4'b1001, cyc);
    check("bp_frames", bus0.frame_count, 1);

    // Coherence: cells go all-ones right after the capture.
    bus0.row_ready = 1'b1;
    start_frame(rand_cells());
    bus0.cells = '1;
    drain(4'hF, cyc);
    check("coh_frames", bus0.frame_count, 2);

    // Dropped requests on rows 2,4,6; back-to-back request on final beat.
    c = rand_cells();
    b = rand_cells();
    start_frame(c);
    for (int k = 0; k < 10; k++) begin
      if (k == 9) begin
        bus0.cells    = b;
        bus0.snap_req = 1'b1;
        push_frame(b);
      end else begin
        bus0.snap_req = (k == 2 || k == 4 || k == 6);
      end
      tick();
    end
    bus0.snap_req = 1'b0;
    check("b2b_valid", bus0.row_valid, 1);
    check("b2b_idx", bus0.row_idx, 0);
    check("b2b_sof", bus0.sof, 1);
    check("b2b_data", bus0.row_data, b[9:0]);
    check("drops_3", bus0.drop_count, 3);
    drain(4'hF, cyc);
    check("b2b_frames", bus0.frame_count, 4);

    // 300 dropped pulses during a stalled frame saturate drop_count.
    bus0.row_ready = 1'b0;
    c = rand_cells();
    start_frame(c);
    for (int i = 0; i < 300; i++) begin
      bus0.cells    = rand_cells();
      bus0.snap_req = 1'b1;
      tick();
      bus0.snap_req = 1'b0;
      tick();
    end
    check("drops_sat", bus0.drop_count, 255);
    drain(4'hF, cyc);
    check("sat_frames", bus0.frame_count, 5);
    check("sat_busy_after", bus0.busy, 0);

    // Single-row array: one beat with sof and eof together.
    bus1.cells     = 4'hA;
    bus1.snap_req  = 1'b1;
    bus1.row_ready = 1'b0;
    tick();
    bus1.snap_req  = 1'b0;
    check("h1_valid", bus1.row_valid, 1);
    check("h1_data", bus1.row_data, 4'hA);
    check("h1_idx", bus1.row_idx, 0);
    check("h1_sof_eof", {bus1.sof, bus1.eof}, 2'b11);
    bus1.cells     = 4'h5;
    bus1.row_ready = 1'b1;
    tick();
    check("h1_valid_after", bus1.row_valid, 0);
    check("h1_frames", bus1.frame_count, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gol_scanout.md
# gol_scanout

Readout engine for the Game of Life cell array. On request it snapshots the full WIDTH*HEIGHT cell-state vector in one cycle, then streams it out one row per beat over a valid/ready handshake with start/end-of-frame flags. It sits beside `gol` as the reader of the state that `gol` writes each generation, and feeds a display or host-capture path. The array keeps evolving during readout; the snapshot guarantees a coherent frame.

## Interface
- `WIDTH`, 10, cells per row (≥2)
- `HEIGHT`, 10, rows per frame (≥1)
- `RW`, derived = max(1, $clog2(HEIGHT)), row index width

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cells`  in  WIDTH*HEIGHT  live cell state; cell i = row i/WIDTH, column i%WIDTH
- `snap_req`  in  1  one-cycle pulse requesting a frame capture
- `row_ready`  in  1  sink accepts current row
- `row_valid`  out  1  row_data/row_idx valid
- `row_data`  out  WIDTH  row r = cells[r*WIDTH +: WIDTH] from snapshot; bit c = column c
- `row_idx`  out  RW  index of row on row_data
- `sof`  out  1  high with row 0 beat
- `eof`  out  1  high with row HEIGHT-1 beat
- `busy`  out  1  frame in progress (state SEND)
- `frame_count`  out  16  completed frames, wraps at 2^16
- `drop_count`  out  8  ignored snap_req pulses, saturates at 255

## Operation
- FSM states: IDLE, SEND.
- IDLE: row_valid=0, row_data=0, row_idx=0, sof=eof=0, busy=0. On snap_req=1: capture `cells` into snapshot register, row counter=0, go SEND.
- SEND: row_valid=1, row_data = snapshot row at row counter, row_idx = counter, sof = (counter==0), eof = (counter==HEIGHT-1), busy=1.
- Beat transfer = row_valid & row_ready at rising edge. Non-final beat: counter+1.
- Final beat (counter==HEIGHT-1): frame_count+1; if snap_req=1 same cycle, recapture `cells`, counter=0, stay SEND (back-to-back frame); else go IDLE.
- snap_req in SEND on any cycle other than a final-beat transfer: ignored, drop_count+1 (saturating at 255); snapshot untouched.
- HEIGHT==1: single beat with sof=eof=1.
- Snapshot register only written on accepted captures; `cells` changes mid-frame never reach row_data.

## Timing
- All outputs registered; reset values: row_valid=0, row_data=0, row_idx=0, sof=0, eof=0, busy=0, frame_count=0, drop_count=0; snapshot cleared, state IDLE.
- Reset asserts asynchronously: outputs go to reset values immediately, any frame in progress is aborted with no completion count.
- Latency: snap_req sampled at edge N → row_valid=1, row 0 presented after edge N.
- Throughput: row_ready held 1 → one row per cycle, frame in exactly HEIGHT cycles; back-to-back frames with no idle cycle when snap_req coincides with the final beat.
- While row_valid=1 and row_ready=0: row_data, row_idx, sof, eof held stable; row_valid never deasserts without a transfer (except reset).
- row_ready is ignored while row_valid=0.

## Test plan
- Reset: rst=0 mid-frame (row 4 of 10) → all outputs 0 within same cycle; after release, row_valid=0 until next snap_req; frame_count=0.
- Basic frame, 10x10, cells[9:0]=10'h3FF, cells[99:90]=10'h201, rest 0, snap_req pulse, row_ready=1 → 10 beats on consecutive cycles starting one cycle after request; row 0 = 0x3FF with sof=1, rows 1–8 = 0, row 9 = 0x201 with eof=1; frame_count=1; busy=0 after.
- Backpressure: row_ready toggled 1,0,0,1,… → each row held stable while stalled, every row 0–9 delivered exactly once in order.
- Coherence: change `cells` to all-ones on the cycle after snap_req → all 10 beats still carry captured values.
- Dropped and back-to-back requests: 3 snap_req pulses during rows 2–6 → drop_count=3; snap_req on final beat → next cycle row_idx=0, sof=1, new snapshot; frame_count=2 after second frame; 300 dropped pulses → drop_count=255.
- HEIGHT=1, WIDTH=4, cells=4'hA → one beat, row_data=0xA, sof=eof=1, row_idx=0.
